// File: rtl/adaptive_golomb_coder_if.sv
// Handshake bundle between the residual source, the Golomb-Rice coder and the output packer.
interface adaptive_golomb_coder_if #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned CODE_WIDTH    = 39,
    parameter int unsigned BIT_AMT_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]    input_data;
    logic                     input_last;
    logic                     input_valid;
    logic                     input_ready;
    logic [CODE_WIDTH-1:0]    output_code_data;
    logic [BIT_AMT_WIDTH-1:0] output_length_data;
    logic                     output_valid;
    logic                     output_ready;

    // Environment side: drives residuals in and consumes codewords.
    modport master (
        output input_data,
        output input_last,
        output input_valid,
        input  input_ready,
        input  output_code_data,
        input  output_length_data,
        input  output_valid,
        output output_ready
    );

    // Coder side.
    modport slave (
        input  input_data,
        input  input_last,
        input  input_valid,
        output input_ready,
        output output_code_data,
        output output_length_data,
        output output_valid,
        input  output_ready
    );
endinterface

// File: rtl/adaptive_golomb_coder.sv
// Adaptive Golomb-Rice coder: one mapped residual in, one (code, length) pair out,
// Rice parameter adapted from running accumulator A and count N.
module adaptive_golomb_coder #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned CODE_WIDTH    = 39,
    parameter int unsigned BIT_AMT_WIDTH = 6,
    parameter int unsigned ACC_WIDTH     = 24,
    parameter int unsigned K_MAX         = 15,
    parameter int unsigned QLIMIT        = 23,
    parameter int unsigned A_INIT        = 4,
    parameter int unsigned N_RESET       = 64
) (
    input logic                    clk,
    input logic                    rst,
    adaptive_golomb_coder_if.slave bus
);
    localparam int unsigned K_WIDTH = $clog2(K_MAX + 1);
    localparam int unsigned N_WIDTH = $clog2(N_RESET + 1);
    localparam logic [CODE_WIDTH-1:0] ESC_PREFIX =
        ((CODE_WIDTH'(1) << QLIMIT) - CODE_WIDTH'(1)) << DATA_WIDTH;

    logic [ACC_WIDTH-1:0]     a_q, a_d, a_sum_c;
    logic [N_WIDTH-1:0]       n_q, n_d, n_inc_c;
    logic [K_WIDTH-1:0]       k_c;
    logic [DATA_WIDTH-1:0]    quot_c;
    logic [CODE_WIDTH-1:0]    code_c, code_q, code_d;
    logic [BIT_AMT_WIDTH-1:0] len_c, len_q, len_d;
    logic                     valid_q, valid_d;
    logic                     in_ready_c, in_fire_c;

    assign in_ready_c = !valid_q || bus.output_ready;
    assign in_fire_c  = bus.input_valid && in_ready_c;

    assign bus.input_ready        = in_ready_c;
    assign bus.output_valid       = valid_q;
    assign bus.output_code_data   = code_q;
    assign bus.output_length_data = len_q;

    // Rice parameter: smallest k with (N << k) >= A, clipped to K_MAX.
    always_comb begin
        k_c = K_WIDTH'(K_MAX);
        for (int i = int'(K_MAX); i >= 0; i--) begin
            if ((ACC_WIDTH'(n_q) << i) >= a_q) begin
                k_c = K_WIDTH'(i);
            end
        end
    end

    // Codeword: unary quotient, stop bit, k remainder bits; escape to raw value on long quotients.
    always_comb begin
        code_c = '0;
        len_c  = '0;
        quot_c = bus.input_data >> k_c;
        if (quot_c < DATA_WIDTH'(QLIMIT)) begin
            code_c = ((((CODE_WIDTH'(1) << quot_c) - CODE_WIDTH'(1)) << k_c) << 1)
                   | (CODE_WIDTH'(bus.input_data) & ((CODE_WIDTH'(1) << k_c) - CODE_WIDTH'(1)));
            len_c  = BIT_AMT_WIDTH'(quot_c) + BIT_AMT_WIDTH'(k_c) + BIT_AMT_WIDTH'(1);
        end else begin
            code_c = ESC_PREFIX | CODE_WIDTH'(bus.input_data);
            len_c  = BIT_AMT_WIDTH'(QLIMIT + DATA_WIDTH);
        end
    end

    // Statistics update: accumulate, halve at N_RESET, reinitialise at block end.
    always_comb begin
        a_d     = a_q;
        n_d     = n_q;
        a_sum_c = a_q + ACC_WIDTH'(bus.input_data);
        n_inc_c = n_q + N_WIDTH'(1);
        if (in_fire_c) begin
            if (bus.input_last) begin
                a_d = ACC_WIDTH'(A_INIT);
                n_d = N_WIDTH'(1);
            end else if (n_inc_c == N_WIDTH'(N_RESET)) begin
                a_d = a_sum_c >> 1;
                n_d = n_inc_c >> 1;
            end else begin
                a_d = a_sum_c;
                n_d = n_inc_c;
            end
        end
    end

    // Output register: load on input transfer, clear on a lone output transfer, else hold.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        len_d   = len_q;
        if (in_fire_c) begin
            valid_d = 1'b1;
            code_d  = code_c;
            len_d   = len_c;
        end else if (bus.output_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q     <= ACC_WIDTH'(A_INIT);
            n_q     <= N_WIDTH'(1);
            valid_q <= 1'b0;
            code_q  <= '0;
            len_q   <= '0;
        end else begin
            a_q     <= a_d;
            n_q     <= n_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            len_q   <= len_d;
        end
    end
endmodule

// File: tb/tb_adaptive_golomb_coder.sv
// Scoreboard bench: two coders (N_RESET 64 and 4) share one stimulus stream.
module tb_adaptive_golomb_coder;
    typedef struct packed {
        logic [38:0] code;
        logic [5:0]  len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    longint ma[2];
    longint mn[2];
    longint nres[2] = '{64, 4};

    adaptive_golomb_coder_if if0 ();
    adaptive_golomb_coder_if if1 ();

    assign if0.input_data   = in_data;
    assign if0.input_last   = in_last;
    assign if0.input_valid  = in_valid;
    assign if0.output_ready = out_ready;
    assign if1.input_data   = in_data;
    assign if1.input_last   = in_last;
    assign if1.input_valid  = in_valid;
    assign if1.output_ready = out_ready;

    adaptive_golomb_coder u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    adaptive_golomb_coder #(.N_RESET(4)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ma[d] = 4;
            mn[d] = 1;
        end
    endtask

    // Reference encoder straight from the coding rules, then statistics update.
    function automatic exp_t model(input int d, input longint v, input logic last);
        exp_t   e;
        longint k = 15;
        longint q;
        for (int i = 15; i >= 0; i--)
            if (mn[d] * (longint'(1) << i) >= ma[d]) k = i;
        q = v / (longint'(1) << k);
        if (q < 23) begin
            e.code = 39'(((longint'(1) << q) - 1) * (longint'(2) << k) + v % (longint'(1) << k));
            e.len  = 6'(q + 1 + k);
        end else begin
            e.code = 39'((((longint'(1) << 23) - 1) << 16) + v);
            e.len  = 6'd39;
        end
        ma[d] = ma[d] + v;
        mn[d] = mn[d] + 1;
        if (mn[d] == nres[d]) begin
            ma[d] = ma[d] / 2;
            mn[d] = mn[d] / 2;
        end
        if (last) begin
            ma[d] = 4;
            mn[d] = 1;
        end
        return e;
    endfunction

    // Drive one cycle; on acceptance push expected results (fixed constants if given).
    task automatic issue(input logic [15:0] v, input logic last, input logic vld, input logic ordy,
                         input logic has_exp, input logic [38:0] ec, input logic [5:0] el);
        exp_t e0, e1;
        @(negedge clk);
        in_data   = v;
        in_last   = last;
        in_valid  = vld;
        out_ready = ordy;
        #1;
        if (vld && if0.input_ready) begin
            e0 = model(0, longint'(v), last);
            e1 = model(1, longint'(v), last);
            if (has_exp) begin
                e0 = '{ec, el};
                e1 = e0;
            end
            q0.push_back(e0);
            q1.push_back(e1);
        end
    endtask

    task automatic send(input logic [15:0] v, input logic last, input logic [38:0] ec, input logic [5:0] el);
        issue(v, last, 1'b1, 1'b1, 1'b1, ec, el);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        #3;
        chk("drain_q0", longint'(q0.size()), 0);
        chk("drain_q1", longint'(q1.size()), 0);
    endtask

    // Monitor: pop and compare whenever an output transfer will occur at the next edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && if0.output_valid && if0.output_ready) begin
                if (q0.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL out0_unexpected actual=%0h expected=none", if0.output_code_data);
                end else begin
                    e = q0.pop_front();
                    chk("code0", longint'(if0.output_code_data), longint'(e.code));
                    chk("len0", longint'(if0.output_length_data), longint'(e.len));
                end
            end
            if (rst && if1.output_valid && if1.output_ready) begin
                if (q1.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL out1_unexpected actual=%0h expected=none", if1.output_code_data);
                end else begin
                    e = q1.pop_front();
                    chk("code1", longint'(if1.output_code_data), longint'(e.code));
                    chk("len1", longint'(if1.output_length_data), longint'(e.len));
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int mode;
        logic [15:0] v;
        rst = 1'b0; in_data = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        model_reset();
        #3;
        chk("rst_valid", longint'(if0.output_valid), 0);
        chk("rst_code", longint'(if0.output_code_data), 0);
        chk("rst_len", longint'(if0.output_length_data), 0);
        chk("rst_ready", longint'(if0.input_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Adaptation from the initial statistics.
        send(16'd5, 1'b0, 39'd9, 6'd4);
        send(16'd0, 1'b0, 39'd0, 6'd4);
        send(16'd0, 1'b1, 39'd0, 6'd3);
        // Halving path (N_RESET=4 instance halves at the third sample).
        send(16'd0, 1'b0, 39'd0, 6'd3);
        send(16'd0, 1'b0, 39'd0, 6'd2);
        send(16'd0, 1'b0, 39'd0, 6'd2);
        send(16'd3, 1'b1, 39'd14, 6'd4);
        // Escape codeword.
        send(16'd200, 1'b1, 39'h7FFFFF00C8, 6'd39);
        // Block end resets statistics between identical samples.
        send(16'd5, 1'b1, 39'd9, 6'd4);
        send(16'd5, 1'b1, 39'd9, 6'd4);
        drain();

        // Backpressure: output held, inputs refused.
        issue(16'd37, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            issue(16'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
            chk("stall_ready", longint'(if0.input_ready), 0);
            chk("stall_valid", longint'(if0.output_valid), 1);
            chk("stall_code", longint'(if0.output_code_data), longint'(q0[0].code));
            chk("stall_len", longint'(if0.output_length_data), longint'(q0[0].len));
        end
        for (int i = 0; i < 6; i++) issue(16'(i * 3), 1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
        drain();

        // Randomised traffic in segments of differing value statistics.
        for (int seg = 0; seg < 16; seg++) begin
            mode = int'($urandom_range(0, 3));
            for (int c = 0; c < 200; c++) begin
                case (mode)
                    0: v = 16'($urandom_range(0, 15));
                    1: v = 16'($urandom_range(0, 255));
                    2: v = 16'($urandom);
                    default: v = 16'd0;
                endcase
                issue(v, (mode != 3) && ($urandom_range(0, 79) == 0),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b0, '0, '0);
            end
        end
        drain();

        // Reset while an output is pending.
        issue(16'd9, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_valid", longint'(if0.output_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid0", longint'(if0.output_valid), 0);
        chk("mid_rst_valid1", longint'(if1.output_valid), 0);
        q0.delete();
        q1.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send(16'd5, 1'b0, 39'd9, 6'd4);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adaptive_golomb_coder.md
Name: adaptive_golomb_coder

Overview:
- Adaptive Golomb-Rice coder; sits directly upstream of coding_output_packer.
- Takes one unsigned mapped residual per handshake and emits a variable-length codeword as a (code, length) pair in the packer's input format.
- Rice parameter k is derived each sample from running statistics: accumulator A and count N, with periodic halving and reset on block end.

Parameters:
- DATA_WIDTH, 16, width of the mapped residual input.
- CODE_WIDTH, 39, width of output_code_data; must be >= QLIMIT+DATA_WIDTH and >= QLIMIT+K_MAX.
- BIT_AMT_WIDTH, 6, width of output_length_data; must hold CODE_WIDTH.
- ACC_WIDTH, 24, width of A; must be >= DATA_WIDTH+log2(N_RESET)+1 and >= log2(N_RESET)+K_MAX+1.
- K_MAX, 15, upper clip for k.
- QLIMIT, 23, quotient escape threshold.
- A_INIT, 4, accumulator value after reset or block end.
- N_RESET, 64, count value that triggers halving.

Ports:
- clk, in, 1, clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- input_data, in, DATA_WIDTH, mapped residual (unsigned).
- input_last, in, 1, last sample of a block.
- input_valid, in, 1, AXIS valid.
- input_ready, out, 1, AXIS ready.
- output_code_data, out, CODE_WIDTH, codeword, right-aligned, MSB-first transmission order, unused upper bits zero.
- output_length_data, out, BIT_AMT_WIDTH, number of valid code bits (1..CODE_WIDTH).
- output_valid, out, 1, AXIS valid.
- output_ready, in, 1, AXIS ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - output_valid=0, output_code_data=0, output_length_data=0.
  - A=A_INIT, N=1.
  - input_ready follows its combinational definition, so it is 1 during reset; no input is accepted while rst=0.
- Handshake:
  - input_ready = !output_valid || output_ready.
  - An input transfer occurs when input_valid && input_ready.
  - Single output register; latency 1 cycle from input transfer to output_valid.
  - Full throughput (1 sample/cycle) when output_ready is held 1.
- Output register hold and clear:
  - While output_valid && !output_ready: output data held stable; no input accepted; A and N frozen.
  - Output transfer without a simultaneous input transfer clears output_valid.
  - Simultaneous output and input transfer reloads the register in the same cycle.
- k selection (combinational from current A, N):
  - k = smallest i in 0..K_MAX with (N<<i) >= A, else K_MAX.
  - Evaluated at ACC_WIDTH bits, no truncation.
- Encoding of value v, with q = v>>k:
  - q < QLIMIT: code = q ones, one zero, then the k LSBs of v; length = q+1+k.
  - q >= QLIMIT (escape): code = QLIMIT ones, then v raw on DATA_WIDTH bits; length = QLIMIT+DATA_WIDTH. No terminating zero.
- Statistics update (on input transfer only, after k is used for the current sample):
  - A += v; N += 1.
  - If the new N == N_RESET: A >>= 1, N >>= 1 (same cycle).
  - If input_last=1: A=A_INIT, N=1, overriding both the update and halving.
- Boundary conditions:
  - A may decay to 0 (all-zero data); k=0 then. N never reaches 0.
  - No internal overflow is possible given the width constraints.
  - Reset mid-operation discards any held output; statistics reinitialise.

Test Plan:
- After reset, feed v=5 -> code 0b1001 (9), length 4 (k=2, q=1). Then v=0 -> code 0, length 4 (A=9, N=2 gives k=3). Then v=0 -> k=2, code 0, length 3.
- After reset, feed v=200 -> escape: code = ((2^23-1)<<16)|200, length 39.
- N_RESET=4: feed 0,0,0 -> after the third sample A=2, N=2. Then v=3 -> k=0, code 0b1110 (14), length 4.
- Feed v=5 with input_last=1, then v=5 again -> both outputs code 9, length 4 (statistics reset between them).
- Hold output_ready=0 for 5 cycles with input_valid=1 -> input_ready=0, output stable, A and N unchanged. Release -> one transfer per cycle, no loss or duplication.
- Assert rst mid-stream with output_valid=1 -> output_valid=0 immediately. After release, v=5 -> code 9, length 4.
